// File: rtl/car_speed_ctrl.sv
// Car speed controller: turns synchronised accelerate/brake/steer buttons into
// y_speed/x_speed, updated once per game tick while the mode controller is in DRIVE.
module car_speed_ctrl #(
    parameter int TICK_DIV    = 2500000,
    parameter int IDLE_SPEED  = 27,
    parameter int MAX_SPEED   = 99,
    parameter int ACCEL_STEP  = 1,
    parameter int BRAKE_STEP  = 2,
    parameter int COAST_TICKS = 8
) (
    input  logic       clock_50,
    input  logic       resetn,
    input  logic       drive_enable,
    input  logic       accel_btn,
    input  logic       brake_btn,
    input  logic       left_btn,
    input  logic       right_btn,
    output logic [6:0] y_speed,
    output logic [1:0] x_speed,
    output logic       at_rest,
    output logic       tick,
    output logic       run_state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (COAST_TICKS > 1) ? $clog2(COAST_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] COAST_LAST  = CW'(COAST_TICKS - 1);
    localparam logic [7:0]    IDLE8       = 8'(IDLE_SPEED);
    localparam logic [7:0]    MAX8        = 8'(MAX_SPEED);
    localparam logic [7:0]    ACCEL8      = 8'(ACCEL_STEP);
    localparam logic [7:0]    BRAKE8      = 8'(BRAKE_STEP);
    localparam logic [7:0]    ACCEL_LIMIT = 8'(MAX_SPEED - ACCEL_STEP);
    localparam logic [7:0]    BRAKE_LIMIT = 8'(IDLE_SPEED + BRAKE_STEP);
    localparam logic [6:0]    IDLE7       = 7'(IDLE_SPEED);

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Buttons packed as {accel, brake, left, right}
    logic [3:0] btn_meta;
    logic [3:0] btn_sync;
    logic       acc_s;
    logic       brk_s;
    logic       lft_s;
    logic       rgt_s;

    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_cnt_next;

    logic [CW-1:0] coast_cnt;
    logic [CW-1:0] coast_next;
    logic [7:0]    y8;
    logic [7:0]    y_next8;
    logic [1:0]    x_next;
    logic          at_rest_next;

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= {accel_btn, brake_btn, left_btn, right_btn};
            btn_sync <= btn_meta;
        end
    end

    assign acc_s = btn_sync[3];
    assign brk_s = btn_sync[2];
    assign lft_s = btn_sync[1];
    assign rgt_s = btn_sync[0];

    always_comb begin
        tick_cnt_next = tick_cnt + TW'(1);
        if (!drive_enable || (tick_cnt == TICK_LAST)) begin
            tick_cnt_next = '0;
        end
    end

    // tick is a flop that mirrors "count == TICK_DIV-1", so it is high for exactly that cycle
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt_next;
            tick     <= drive_enable && (tick_cnt_next == TICK_LAST);
        end
    end

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            state <= S_HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_HOLD:  if (drive_enable)  state_next = S_RUN;
            S_RUN:   if (!drive_enable) state_next = S_HOLD;
            default: state_next = S_HOLD;
        endcase
    end

    // Leaving RUN forces idle outputs in the same edge, so disabling never waits for a tick
    always_comb begin
        y8         = {1'b0, y_speed};
        y_next8    = y8;
        x_next     = x_speed;
        coast_next = coast_cnt;
        if (state_next == S_HOLD) begin
            y_next8    = IDLE8;
            x_next     = 2'd0;
            coast_next = '0;
        end else if ((state == S_RUN) && tick) begin
            if (brk_s) begin
                coast_next = '0;
                y_next8    = (y8 >= BRAKE_LIMIT) ? (y8 - BRAKE8) : IDLE8;
            end else if (acc_s) begin
                coast_next = '0;
                y_next8    = (y8 >= ACCEL_LIMIT) ? MAX8 : (y8 + ACCEL8);
            end else if (coast_cnt == COAST_LAST) begin
                coast_next = '0;
                y_next8    = (y8 > IDLE8) ? (y8 - 8'd1) : IDLE8;
            end else begin
                coast_next = coast_cnt + CW'(1);
            end

            // Steering looks at the speed before this tick's update
            if (y_speed == IDLE7) begin
                x_next = 2'd0;
            end else if (lft_s && !rgt_s) begin
                x_next = 2'd1;
            end else if (rgt_s && !lft_s) begin
                x_next = 2'd2;
            end else begin
                x_next = 2'd0;
            end
        end
        at_rest_next = (y_next8 == IDLE8) && (x_next == 2'd0);
    end

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            y_speed   <= IDLE7;
            x_speed   <= 2'd0;
            at_rest   <= 1'b1;
            coast_cnt <= '0;
        end else begin
            y_speed   <= y_next8[6:0];
            x_speed   <= x_next;
            at_rest   <= at_rest_next;
            coast_cnt <= coast_next;
        end
    end

    assign run_state = (state == S_RUN);

endmodule

// File: tb/tb_car_speed_ctrl.sv
// Directed bench for car_speed_ctrl: a vector table of tick-stepped moves plus
// hand sequences for reset, disable/re-enable and tick-boundary steering.
module tb_car_speed_ctrl;

    logic       clock_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       drive_enable = 1'b0;
    logic       accel_btn = 1'b0;
    logic       brake_btn = 1'b0;
    logic       left_btn = 1'b0;
    logic       right_btn = 1'b0;
    logic [6:0] y_speed;
    logic [1:0] x_speed;
    logic       at_rest;
    logic       tick;
    logic       run_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic de;
        logic acc;
        logic brk;
        logic lft;
        logic rgt;
        int   nticks;
        int   exp_y;
        int   exp_x;
        int   exp_rest;
    } vec_t;

    vec_t vecs[23];

    car_speed_ctrl #(
        .TICK_DIV(4),
        .IDLE_SPEED(27),
        .MAX_SPEED(99),
        .ACCEL_STEP(1),
        .BRAKE_STEP(2),
        .COAST_TICKS(3)
    ) dut (
        .clock_50(clock_50),
        .resetn(resetn),
        .drive_enable(drive_enable),
        .accel_btn(accel_btn),
        .brake_btn(brake_btn),
        .left_btn(left_btn),
        .right_btn(right_btn),
        .y_speed(y_speed),
        .x_speed(x_speed),
        .at_rest(at_rest),
        .tick(tick),
        .run_state(run_state)
    );

    always #5 clock_50 = ~clock_50;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input int ey, input int ex, input int er);
        check({name, ".y_speed"}, int'(y_speed), ey);
        check({name, ".x_speed"}, int'(x_speed), ex);
        check({name, ".at_rest"}, int'(at_rest), er);
    endtask

    // Returns at the falling edge just after the clock edge that consumed a tick
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock_50);
            if (tick) seen = 1'b1;
        end
        if (seen) begin
            @(negedge clock_50);
        end else begin
            checks++;
            errors++;
            $display("FAIL tick_timeout actual no tick required tick within 20 cycles");
        end
    endtask

    task automatic set_btns(input logic de, input logic a, input logic b, input logic l, input logic r);
        drive_enable = de;
        accel_btn    = a;
        brake_btn    = b;
        left_btn     = l;
        right_btn    = r;
    endtask

    initial begin
        //          de acc brk lft rgt ticks  y  x rest
        vecs[0]  = '{1, 1, 0, 0, 0,  1, 28, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 0,  1, 29, 0, 0};
        vecs[2]  = '{1, 1, 0, 0, 0, 70, 99, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 0,  5, 99, 0, 0};
        vecs[4]  = '{1, 0, 1, 0, 0, 34, 31, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 0,  3, 30, 0, 0};
        vecs[6]  = '{1, 1, 1, 0, 0,  1, 28, 0, 0};
        vecs[7]  = '{1, 1, 1, 0, 0,  1, 27, 0, 1};
        vecs[8]  = '{1, 1, 1, 0, 0,  3, 27, 0, 1};
        vecs[9]  = '{1, 0, 0, 1, 0,  1, 27, 0, 1};
        vecs[10] = '{1, 1, 0, 0, 0, 13, 40, 0, 0};
        vecs[11] = '{1, 0, 0, 0, 0,  1, 40, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 0,  1, 40, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 0,  1, 39, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 0,  3, 38, 0, 0};
        vecs[15] = '{1, 0, 0, 0, 0, 33, 27, 0, 1};
        vecs[16] = '{1, 0, 0, 0, 0,  6, 27, 0, 1};
        vecs[17] = '{1, 1, 0, 0, 0, 23, 50, 0, 0};
        vecs[18] = '{1, 0, 0, 1, 0,  1, 50, 1, 0};
        vecs[19] = '{1, 0, 0, 0, 1,  1, 50, 2, 0};
        vecs[20] = '{1, 0, 0, 1, 1,  1, 49, 0, 0};
        vecs[21] = '{1, 0, 0, 0, 0,  1, 49, 0, 0};
        vecs[22] = '{1, 1, 0, 0, 1, 11, 60, 2, 0};

        // Reset state
        repeat (3) @(negedge clock_50);
        check_outs("reset", 27, 0, 1);
        check("reset.tick", int'(tick), 0);
        check("reset.run_state", int'(run_state), 0);
        resetn = 1'b1;

        // Mid-run asynchronous reset
        @(negedge clock_50);
        set_btns(1, 1, 0, 0, 0);
        repeat (3) wait_tick();
        check_outs("pre_reset", 30, 0, 0);
        #3 resetn = 1'b0;
        #1 check_outs("async_reset", 27, 0, 1);
        check("async_reset.tick", int'(tick), 0);
        set_btns(0, 0, 0, 0, 0);
        repeat (2) @(negedge clock_50);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_50);
            check_outs("hold", 27, 0, 1);
            check("hold.tick", int'(tick), 0);
        end

        // Table: each row is applied right after a tick, then stepped nticks ticks
        for (int v = 0; v < 23; v++) begin
            set_btns(vecs[v].de, vecs[v].acc, vecs[v].brk, vecs[v].lft, vecs[v].rgt);
            for (int t = 0; t < vecs[v].nticks; t++) wait_tick();
            check_outs($sformatf("vec%0d", v), vecs[v].exp_y, vecs[v].exp_x, vecs[v].exp_rest);
            check($sformatf("vec%0d.tick", v), int'(tick), 0);
        end

        // Disable mid-motion: idle outputs on the very next cycle
        set_btns(0, 0, 0, 0, 0);
        @(negedge clock_50);
        check_outs("disable", 27, 0, 1);
        check("disable.tick", int'(tick), 0);
        check("disable.run_state", int'(run_state), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_50);
            check("disabled.tick", int'(tick), 0);
        end

        // Re-enable: counter restarts at 0, so tick appears after the third edge
        set_btns(1, 1, 0, 0, 0);
        @(negedge clock_50);
        check("reen.tick1", int'(tick), 0);
        @(negedge clock_50);
        check("reen.tick2", int'(tick), 0);
        @(negedge clock_50);
        check("reen.tick3", int'(tick), 1);
        check("reen.y_before", int'(y_speed), 27);
        @(negedge clock_50);
        check_outs("reen", 28, 0, 0);

        // Steering only changes on the tick boundary
        set_btns(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_50);
            check("steer_wait.x_speed", int'(x_speed), 0);
        end
        check("steer_wait.tick", int'(tick), 1);
        @(negedge clock_50);
        check_outs("steer", 28, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
